rand_range_sampler: RTL and testbench

- Downstream consumer of the 8-bit LFSR random stream (`lfsr.rand_num`).
- Converts raw LFSR words into uniformly distributed values in [0, N) by mask-and-reject sampling.
- Buffers accepted values in a small FIFO behind a valid/ready output.
- Keeps accept/reject statistics and flags a stuck or degenerate source.

---
 rtl/rand_range_sampler.sv | 131 +++++++++++++
 tb/tb_rand_range_sampler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_range_sampler.sv
// Mask-and-reject sampler: maps raw LFSR words onto a uniform range [0, N),
// buffers accepted values in a small FIFO and tracks accept/reject statistics.
module rand_range_sampler #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rand_num,
  input  logic              rand_valid,
  input  logic              cfg_load,
  input  logic [DATA_W-1:0] cfg_range,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  accept_cnt,
  output logic [CNT_W-1:0]  reject_cnt
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Smallest all-ones mask covering 0..n-1: smear the top set bit of n-1 downward.
  function automatic logic [DATA_W-1:0] range_mask(input logic [DATA_W-1:0] n);
    logic [DATA_W-1:0] m;
    if (n == '0) return '0;
    m = n - DATA_W'(1);
    for (int i = 1; i < DATA_W; i = i * 2) m = m | (m >> i);
    return m;
  endfunction

  state_t            state;
  logic [DATA_W-1:0] range_n;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FCNT_W-1:0] fifo_cnt;
  logic [FCNT_W-1:0] fifo_cnt_next;
  logic [TO_W-1:0]   consec;
  logic [TO_W-1:0]   consec_inc;
  logic [DATA_W-1:0] cand;
  logic              fifo_full;
  logic              sample;
  logic              push;
  logic              reject;
  logic              pop;

  always_comb begin
    // NOTE: every signal gets a value on every path through this block, so no latches.
    cand          = rand_num & mask;
    fifo_full     = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
    // Full check uses the count before any pop this cycle.
    sample        = (state == S_RUN) && rand_valid && !fifo_full;
    push          = sample && (cand < range_n);
    reject        = sample && !(cand < range_n);
    pop           = (fifo_cnt != '0) && out_ready;
    fifo_cnt_next = fifo_cnt;
    if (push && !pop)      fifo_cnt_next = fifo_cnt + FCNT_W'(1);
    else if (pop && !push) fifo_cnt_next = fifo_cnt - FCNT_W'(1);
    consec_inc    = (consec == TO_W'(TIMEOUT)) ? consec : consec + TO_W'(1);
  end

  // NOTE: the storage array has no reset; emptiness is defined by the pointers and count.
  always_ff @(posedge clk) begin
    if (push && !cfg_load) mem[wr_ptr] <= cand;
  end

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      range_n     <= '0;
      mask        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      consec      <= '0;
      timeout_err <= 1'b0;
      accept_cnt  <= '0;
      reject_cnt  <= '0;
    end else if (cfg_load) begin
      range_n     <= cfg_range;
      mask        <= range_mask(cfg_range);
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      consec      <= '0;
      timeout_err <= 1'b0;
      accept_cnt  <= '0;
      reject_cnt  <= '0;
      state       <= (cfg_range == '0) ? S_IDLE : S_RUN;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt_next;

      if (push) begin
        consec <= '0;
        if (accept_cnt != '1) accept_cnt <= accept_cnt + CNT_W'(1);
      end
      if (reject) begin
        consec <= consec_inc;
        if (reject_cnt != '1) reject_cnt <= reject_cnt + CNT_W'(1);
        if (consec_inc == TO_W'(TIMEOUT)) timeout_err <= 1'b1;
      end

      case (state)
        S_RUN:   if (fifo_cnt_next == FCNT_W'(FIFO_DEPTH)) state <= S_HOLD;
        S_HOLD:  if (pop) state <= S_RUN;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = (fifo_cnt != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_rand_range_sampler.sv
// Bench for rand_range_sampler: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_rand_range_sampler;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] rand_num;
  logic              rand_valid;
  logic              cfg_load;
  logic [DATA_W-1:0] cfg_range;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              timeout_err;
  logic [CNT_W-1:0]  accept_cnt;
  logic [CNT_W-1:0]  reject_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  rand_range_sampler #(
    .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .rand_num(rand_num), .rand_valid(rand_valid),
    .cfg_load(cfg_load), .cfg_range(cfg_range), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .timeout_err(timeout_err), .accept_cnt(accept_cnt), .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: sampler state as plain numbers and a queue.
  bit m_run;
  bit m_to;
  int m_n, m_mask, m_acc, m_rej, m_consec;
  int q[$];

  function automatic int mask_of(input int n);
    int k = 0;
    while ((1 << k) < n) k++;
    return (1 << k) - 1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_to = 0; m_n = 0; m_mask = 0;
    m_acc = 0; m_rej = 0; m_consec = 0;
    q.delete();
  endtask

  task automatic model_step();
    bit do_pop, do_sample;
    int c;
    do_pop    = (q.size() > 0) && out_ready;
    do_sample = m_run && rand_valid && (q.size() < DEPTH);
    if (cfg_load) begin
      model_reset();
      m_n    = int'(cfg_range);
      m_mask = mask_of(m_n);
      m_run  = (m_n != 0);
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_sample) begin
        c = int'(rand_num) & m_mask;
        if (c < m_n) begin
          q.push_back(c);
          if (m_acc < CNT_MAX) m_acc++;
          m_consec = 0;
        end else begin
          if (m_rej < CNT_MAX) m_rej++;
          if (m_consec < TIMEOUT) m_consec++;
          if (m_consec == TIMEOUT) m_to = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_cfg(input int n);
    cfg_load = 1; cfg_range = DATA_W'(n); rand_valid = 0;
    tick();
    cfg_load = 0;
  endtask

  task automatic feed(input int v);
    rand_valid = 1; rand_num = DATA_W'(v);
    tick();
    rand_valid = 0;
  endtask

  task automatic test_reset();
    rst = 0; rand_num = 0; rand_valid = 0; cfg_load = 0; cfg_range = 0; out_ready = 0;
    model_reset();
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    n_tests++; if (out_data !== 8'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d exp 0", out_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_tests++; if ({timeout_err, accept_cnt, reject_cnt} !== 33'd0) begin n_fail++; $display("FAIL reset_stats: got to=%b acc=%0d rej=%0d exp 0", timeout_err, accept_cnt, reject_cnt); end
    @(negedge clk);
    rst = 1;
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got busy=%b exp 0", busy); end
  endtask

  task automatic test_basic();
    out_ready = 1;
    do_cfg(6);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b exp 1", busy); end
    feed(8'h6A);
    n_tests++; if (out_valid !== 1'b1 || out_data !== 8'd2) begin n_fail++; $display("FAIL basic_first: got v=%b d=%0d exp v=1 d=2", out_valid, out_data); end
    feed(8'h0F);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_reject: got v=%b exp 0", out_valid); end
    feed(8'h35);
    n_tests++; if (out_valid !== 1'b1 || out_data !== 8'd5) begin n_fail++; $display("FAIL basic_second: got v=%b d=%0d exp v=1 d=5", out_valid, out_data); end
    feed(8'h06);
    n_tests++; if (accept_cnt !== 16'd2 || reject_cnt !== 16'd2) begin n_fail++; $display("FAIL basic_counts: got acc=%0d rej=%0d exp 2/2", accept_cnt, reject_cnt); end
  endtask

  task automatic test_hold();
    out_ready = 0;
    do_cfg(6);
    for (int v = 0; v < 6; v++) feed(v);
    feed(7);
    n_tests++; if (accept_cnt !== 16'd4 || reject_cnt !== 16'd0) begin n_fail++; $display("FAIL hold_counts: got acc=%0d rej=%0d exp 4/0", accept_cnt, reject_cnt); end
    n_tests++; if (busy !== 1'b1 || out_data !== 8'd0) begin n_fail++; $display("FAIL hold_head: got busy=%b d=%0d exp 1/0", busy, out_data); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (out_valid !== 1'b1 || out_data !== DATA_W'(i)) begin n_fail++; $display("FAIL hold_drain%0d: got v=%b d=%0d exp v=1 d=%0d", i, out_valid, out_data, i); end
      if (i == 0) begin
        rand_valid = 1; rand_num = 8'd1;
      end
      tick();
      rand_valid = 0;
    end
    n_tests++; if (out_valid !== 1'b0 || accept_cnt !== 16'd4) begin n_fail++; $display("FAIL hold_full_gate: got v=%b acc=%0d exp v=0 acc=4", out_valid, accept_cnt); end
    feed(3);
    n_tests++; if (out_data !== 8'd3 || accept_cnt !== 16'd5) begin n_fail++; $display("FAIL hold_rerun: got d=%0d acc=%0d exp 3/5", out_data, accept_cnt); end
    tick();
  endtask

  task automatic test_ranges();
    out_ready = 1;
    do_cfg(1);
    for (int i = 0; i < 8; i++) begin
      feed(int'($urandom_range(0, 255)));
      n_tests++; if (out_valid !== 1'b1 || out_data !== 8'd0) begin n_fail++; $display("FAIL range1_%0d: got v=%b d=%0d exp v=1 d=0", i, out_valid, out_data); end
    end
    n_tests++; if (reject_cnt !== 16'd0 || accept_cnt !== 16'd8) begin n_fail++; $display("FAIL range1_counts: got acc=%0d rej=%0d exp 8/0", accept_cnt, reject_cnt); end
    do_cfg(255);
    feed(8'hFF);
    n_tests++; if (out_valid !== 1'b0 || reject_cnt !== 16'd1) begin n_fail++; $display("FAIL range255_ff: got v=%b rej=%0d exp 0/1", out_valid, reject_cnt); end
    feed(8'hFE);
    n_tests++; if (out_valid !== 1'b1 || out_data !== 8'hFE) begin n_fail++; $display("FAIL range255_fe: got v=%b d=%0h exp 1/fe", out_valid, out_data); end
    tick();
  endtask

  task automatic test_timeout();
    out_ready = 0;
    do_cfg(5);
    rand_valid = 1; rand_num = 8'h07;
    repeat (TIMEOUT - 1) tick();
    n_tests++; if (timeout_err !== 1'b0 || reject_cnt !== 16'd63) begin n_fail++; $display("FAIL timeout_early: got to=%b rej=%0d exp 0/63", timeout_err, reject_cnt); end
    tick();
    n_tests++; if (timeout_err !== 1'b1 || reject_cnt !== 16'd64) begin n_fail++; $display("FAIL timeout_set: got to=%b rej=%0d exp 1/64", timeout_err, reject_cnt); end
    rand_num = 8'h02;
    tick();
    rand_num = 8'h07;
    tick(); tick();
    rand_valid = 0;
    n_tests++; if (timeout_err !== 1'b1 || out_data !== 8'd2 || accept_cnt !== 16'd1 || reject_cnt !== 16'd66) begin n_fail++; $display("FAIL timeout_sticky: got to=%b d=%0d acc=%0d rej=%0d exp 1/2/1/66", timeout_err, out_data, accept_cnt, reject_cnt); end
    do_cfg(5);
    n_tests++; if (timeout_err !== 1'b0 || accept_cnt !== 16'd0 || reject_cnt !== 16'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got to=%b acc=%0d rej=%0d v=%b exp all 0", timeout_err, accept_cnt, reject_cnt, out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    do_cfg(6);
    feed(1); feed(2); feed(3);
    n_tests++; if (out_valid !== 1'b1 || accept_cnt !== 16'd3) begin n_fail++; $display("FAIL rstmid_pre: got v=%b acc=%0d exp 1/3", out_valid, accept_cnt); end
    #2 rst = 0;
    model_reset();
    #1;
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || accept_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_async: got v=%b busy=%b acc=%0d exp 0/0/0", out_valid, busy, accept_cnt); end
    @(negedge clk);
    rst = 1;
    feed(1);
    n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got busy=%b v=%b exp 0/0", busy, out_valid); end
  endtask

  task automatic test_idle_and_abort();
    out_ready = 0;
    do_cfg(0);
    for (int i = 0; i < 4; i++) feed(int'($urandom_range(0, 255)));
    n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0 || accept_cnt !== 16'd0 || reject_cnt !== 16'd0) begin n_fail++; $display("FAIL idle_zero: got busy=%b v=%b acc=%0d rej=%0d exp all 0", busy, out_valid, accept_cnt, reject_cnt); end
    do_cfg(6);
    feed(1); feed(2);
    cfg_load = 1; cfg_range = 8'd6; rand_valid = 1; rand_num = 8'd3;
    tick();
    cfg_load = 0; rand_valid = 0;
    n_tests++; if (out_valid !== 1'b0 || accept_cnt !== 16'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_flush: got v=%b acc=%0d busy=%b exp 0/0/1", out_valid, accept_cnt, busy); end
    feed(4);
    n_tests++; if (out_data !== 8'd4 || accept_cnt !== 16'd1) begin n_fail++; $display("FAIL abort_resume: got d=%0d acc=%0d exp 4/1", out_data, accept_cnt); end
  endtask

  task automatic test_random();
    int r;
    do_cfg(int'($urandom_range(1, 255)));
    for (int cyc = 0; cyc < 600; cyc++) begin
      cfg_load = ($urandom_range(0, 39) == 0);
      r = int'($urandom_range(0, 9));
      cfg_range  = (r == 0) ? 8'd0 : (r == 1) ? 8'd1 : (r == 2) ? 8'd255 : DATA_W'($urandom_range(1, 255));
      rand_valid = ($urandom_range(0, 3) != 0);
      rand_num   = DATA_W'($urandom_range(0, 255));
      out_ready  = ($urandom_range(0, 1) == 1);
      tick();
      n_tests++; if (out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rand_valid@%0d: got %b exp %b", cyc, out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        n_tests++; if (out_data !== DATA_W'(q[0])) begin n_fail++; $display("FAIL rand_data@%0d: got %0d exp %0d", cyc, out_data, q[0]); end
      end
      n_tests++; if (accept_cnt !== CNT_W'(m_acc) || reject_cnt !== CNT_W'(m_rej)) begin n_fail++; $display("FAIL rand_counts@%0d: got %0d/%0d exp %0d/%0d", cyc, accept_cnt, reject_cnt, m_acc, m_rej); end
      n_tests++; if (busy !== m_run || timeout_err !== m_to) begin n_fail++; $display("FAIL rand_flags@%0d: got busy=%b to=%b exp %b/%b", cyc, busy, timeout_err, m_run, m_to); end
    end
    cfg_load = 0; rand_valid = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_ranges();
    test_timeout();
    test_reset_mid();
    test_idle_and_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by time limit, exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
